// File: rtl/rf_scoreboard_if.sv
// Decode/write-back side bundle of the register-file write scoreboard.
// master = pipeline stages driving events, slave = the scoreboard.
interface rf_scoreboard_if;
  localparam int unsigned RA_W = 5;
  localparam int unsigned WB_W = 38;

  logic            ds_valid;
  logic [RA_W-1:0] ds_rj;
  logic [RA_W-1:0] ds_rk;
  logic            ds_rj_used;
  logic            ds_rk_used;
  logic            ds_rf_we;
  logic [RA_W-1:0] ds_rf_waddr;
  logic            ds_issue;
  logic [WB_W-1:0] ws_rf_collect;
  logic            flush;
  logic            ds_stall;
  logic [RA_W-1:0] inflight_cnt;
  logic            sb_err;

  modport master (
    output ds_valid, ds_rj, ds_rk, ds_rj_used, ds_rk_used,
    output ds_rf_we, ds_rf_waddr, ds_issue, ws_rf_collect, flush,
    input  ds_stall, inflight_cnt, sb_err
  );

  modport slave (
    input  ds_valid, ds_rj, ds_rk, ds_rj_used, ds_rk_used,
    input  ds_rf_we, ds_rf_waddr, ds_issue, ws_rf_collect, flush,
    output ds_stall, inflight_cnt, sb_err
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Register-file write scoreboard: per-register pending-write counters that
// stall decode on RAW hazards and on a destination counter at its limit.
module rf_scoreboard #(
  parameter int unsigned CNT_W = 2
) (
  input  logic           clk,
  input  logic           resetn,
  rf_scoreboard_if.slave sb
);
  localparam int unsigned RA_W  = 5;
  localparam int unsigned NREG  = 32;
  localparam int unsigned TOT_W = CNT_W + RA_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [TOT_W-1:0] TOT_SAT = TOT_W'(31);

  logic [CNT_W-1:0] cnt_q [1:NREG-1];
  logic [CNT_W-1:0] cnt_d [1:NREG-1];
  logic [CNT_W-1:0] cnt_v [0:NREG-1];
  logic [TOT_W-1:0] tot_q;
  logic [TOT_W-1:0] tot_d;
  logic [RA_W-1:0]  inflight_q;
  logic [RA_W-1:0]  inflight_d;
  logic             err_q;
  logic             err_d;

  logic             ie;
  logic             re;
  logic [RA_W-1:0]  ia;
  logic [RA_W-1:0]  ra;
  logic             h_j;
  logic             h_k;
  logic             h_d;
  logic             stall_c;
  logic             unused_wdata;

  // Write-back data is carried on the bundle but never needed here.
  assign unused_wdata = ^sb.ws_rf_collect[31:0];

  // Qualified issue and retire events; r0 is never tracked.
  always_comb begin
    ia = sb.ds_rf_waddr;
    ra = sb.ws_rf_collect[36:32];
    ie = sb.ds_issue & sb.ds_rf_we & (ia != '0);
    re = sb.ws_rf_collect[37] & (ra != '0);
  end

  // Read view with a permanently empty slot for r0.
  always_comb begin
    cnt_v[0] = '0;
    for (int r = 1; r < int'(NREG); r++) begin
      cnt_v[r] = cnt_q[r];
    end
  end

  // Counter, running-total and error next state; flush overrides everything.
  always_comb begin
    err_d = err_q;
    tot_d = tot_q;
    for (int r = 1; r < int'(NREG); r++) begin
      cnt_d[r] = cnt_q[r];
      if (sb.flush) begin
        cnt_d[r] = '0;
      end else if (ie && (ia == RA_W'(r)) && !(re && (ra == RA_W'(r)))) begin
        if (cnt_q[r] == CNT_MAX) begin
          err_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] + CNT_W'(1);
          tot_d    = tot_d + TOT_W'(1);
        end
      end else if (re && (ra == RA_W'(r)) && !(ie && (ia == RA_W'(r)))) begin
        if (cnt_q[r] == '0) begin
          err_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] - CNT_W'(1);
          tot_d    = tot_d - TOT_W'(1);
        end
      end
    end
    if (sb.flush) begin
      tot_d = '0;
    end
    inflight_d = (tot_d > TOT_SAT) ? RA_W'(31) : tot_d[RA_W-1:0];
  end

  // Hazard detection from current counters only; independent of ds_issue.
  always_comb begin
    h_j     = sb.ds_rj_used & (sb.ds_rj != '0) & (cnt_v[sb.ds_rj] != '0);
    h_k     = sb.ds_rk_used & (sb.ds_rk != '0) & (cnt_v[sb.ds_rk] != '0);
    h_d     = sb.ds_rf_we & (ia != '0) & (cnt_v[ia] == CNT_MAX);
    stall_c = sb.ds_valid & (h_j | h_k | h_d);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 1; r < int'(NREG); r++) begin
        cnt_q[r] <= '0;
      end
      tot_q      <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      for (int r = 1; r < int'(NREG); r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      tot_q      <= tot_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign sb.ds_stall     = stall_c;
  assign sb.inflight_cnt = inflight_q;
  assign sb.sb_err       = err_q;
endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard: per-register pending-count model checked
// every cycle, plus hand-computed expectations at key points.
module tb_rf_scoreboard;
  localparam int MAXV = 3;

  logic clk = 1'b0;
  logic resetn;
  int   cyc_n = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  int   pend [32] = '{default: 0};
  int   dlt  [32] = '{default: 0};
  logic merr = 1'b0;

  int   lit_cyc = -1;
  logic lit_stall;
  int   lit_infl;
  logic lit_err;

  rf_scoreboard_if bus ();

  rf_scoreboard #(.CNT_W(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .sb     (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Reference: signed per-register deltas applied then clamped to [0, MAXV].
  always @(posedge clk or negedge resetn) begin
    if (!resetn || bus.flush) begin
      for (int r = 0; r < 32; r++) pend[r] = 0;
      if (!resetn) merr = 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) dlt[r] = 0;
      if (bus.ds_issue && bus.ds_rf_we) dlt[bus.ds_rf_waddr] += 1;
      if (bus.ws_rf_collect[37]) dlt[bus.ws_rf_collect[36:32]] -= 1;
      for (int r = 1; r < 32; r++) begin
        int n;
        n = pend[r] + dlt[r];
        if (n < 0) begin merr = 1'b1; n = 0; end
        else if (n > MAXV) begin merr = 1'b1; n = MAXV; end
        pend[r] = n;
      end
    end
  end

  function automatic logic model_stall();
    logic hj, hk, hd;
    hj = bus.ds_rj_used && bus.ds_rj != 0 && pend[bus.ds_rj] > 0;
    hk = bus.ds_rk_used && bus.ds_rk != 0 && pend[bus.ds_rk] > 0;
    hd = bus.ds_rf_we && bus.ds_rf_waddr != 0 && pend[bus.ds_rf_waddr] == MAXV;
    return bus.ds_valid && (hj || hk || hd);
  endfunction

  function automatic int model_total();
    int s = 0;
    for (int r = 1; r < 32; r++) s += pend[r];
    return (s > 31) ? 31 : s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d, t=%0t)", nm, act, exp, cyc_n, $time);
    end
  endtask

  // Single compare process, sampling on the falling edge.
  always @(negedge clk) begin
    chk("ds_stall", 32'(bus.ds_stall), 32'(model_stall()));
    chk("inflight_cnt", 32'(bus.inflight_cnt), 32'(model_total()));
    chk("sb_err", 32'(bus.sb_err), 32'(merr));
    if (cyc_n == lit_cyc) begin
      chk("lit_stall", 32'(bus.ds_stall), 32'(lit_stall));
      chk("lit_inflight", 32'(bus.inflight_cnt), 32'(lit_infl));
      chk("lit_err", 32'(bus.sb_err), 32'(lit_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input logic s, input int infl, input logic e);
    lit_cyc   = cyc_n;
    lit_stall = s;
    lit_infl  = infl;
    lit_err   = e;
  endtask

  task automatic set_dec(input logic v, input logic [4:0] rj, input logic rju,
                         input logic [4:0] rk, input logic rku, input logic we,
                         input logic [4:0] wa, input logic iss);
    bus.ds_valid    = v;
    bus.ds_rj       = rj;
    bus.ds_rj_used  = rju;
    bus.ds_rk       = rk;
    bus.ds_rk_used  = rku;
    bus.ds_rf_we    = we;
    bus.ds_rf_waddr = wa;
    bus.ds_issue    = iss;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] a);
    bus.ws_rf_collect = {we, a, $urandom()};
  endtask

  task automatic idle();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0);
    bus.flush = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    idle();
    repeat (3) tick();
    lit(0, 0, 0);
    tick();
    resetn = 1'b1;

    // reset idle, add r3,r1,r2 then retire r3
    set_dec(1, 1, 1, 2, 1, 1, 3, 1); lit(0, 0, 0); tick();
    idle(); set_wb(1, 3); lit(0, 1, 0); tick();
    idle(); lit(0, 0, 0); tick();

    // RAW on r5
    set_dec(1, 0, 0, 0, 0, 1, 5, 1); tick();
    set_dec(1, 5, 1, 0, 0, 0, 0, 0); lit(1, 1, 0); tick();
    lit(1, 1, 0); tick();
    set_wb(1, 5); lit(1, 1, 0); tick();
    set_wb(0, 0); lit(0, 0, 0); tick();

    // same-cycle issue and retire on r7
    set_dec(1, 0, 0, 0, 0, 1, 7, 1); tick();
    set_dec(1, 7, 1, 0, 0, 1, 7, 1); set_wb(1, 7); lit(1, 1, 0); tick();
    set_dec(1, 7, 1, 0, 0, 0, 0, 0); set_wb(0, 0); lit(1, 1, 0); tick();
    set_wb(1, 7); lit(1, 1, 0); tick();
    set_wb(0, 0); lit(0, 0, 0); tick();

    // r0 and unused sources
    set_dec(1, 0, 1, 0, 1, 1, 0, 1); lit(0, 0, 0); tick();
    lit(0, 0, 0);
    set_dec(1, 0, 0, 0, 0, 1, 9, 1); tick();
    set_dec(1, 0, 1, 9, 0, 0, 0, 0); lit(0, 1, 0); tick();
    set_dec(1, 0, 0, 9, 1, 0, 0, 0); lit(1, 1, 0); tick();
    idle(); set_wb(1, 9); tick();
    set_wb(0, 0); lit(0, 0, 0); tick();

    // WAW saturation on r4
    repeat (3) begin set_dec(1, 0, 0, 0, 0, 1, 4, 1); tick(); end
    set_dec(1, 0, 0, 0, 0, 1, 4, 0); lit(1, 3, 0); tick();
    set_dec(1, 0, 0, 0, 0, 1, 4, 1); lit(1, 3, 0); tick();
    set_dec(1, 0, 0, 0, 0, 1, 4, 0); lit(1, 3, 1); tick();
    set_dec(1, 4, 1, 0, 0, 0, 0, 0); set_wb(1, 4); lit(1, 3, 1); tick();
    lit(1, 2, 1); tick();
    lit(1, 1, 1); tick();
    set_wb(0, 0); lit(0, 0, 1); tick();

    // reset clears the sticky error
    idle(); resetn = 1'b0; lit(0, 0, 0); tick();
    resetn = 1'b1; lit(0, 0, 0); tick();

    // running total saturates at 31 (33 writes outstanding)
    for (int r = 1; r <= 11; r++) begin
      repeat (3) begin set_dec(1, 0, 0, 0, 0, 1, 5'(r), 1); tick(); end
    end
    idle(); lit(0, 31, 0); tick();
    set_wb(1, 1); lit(0, 31, 0); tick();
    set_wb(1, 2); tick();
    set_wb(1, 3); tick();
    set_wb(0, 0); lit(0, 30, 0); tick();
    resetn = 1'b0; lit(0, 0, 0); tick();
    resetn = 1'b1; tick();

    // flush with simultaneous retire of r2
    set_dec(1, 0, 0, 0, 0, 1, 2, 1); tick();
    set_dec(1, 0, 0, 0, 0, 1, 6, 1); tick();
    set_dec(1, 0, 0, 0, 0, 1, 8, 1); tick();
    set_dec(1, 6, 1, 0, 0, 0, 0, 0); set_wb(1, 2); bus.flush = 1'b1; lit(1, 3, 0); tick();
    bus.flush = 1'b0; set_wb(0, 0); lit(0, 0, 0); tick();
    set_dec(1, 2, 1, 8, 1, 0, 0, 0); lit(0, 0, 0); tick();

    // asynchronous reset between edges with r2 pending
    set_dec(1, 0, 0, 0, 0, 1, 2, 1); tick();
    set_dec(1, 2, 1, 0, 0, 0, 0, 0); lit(1, 1, 0); tick();
    #2 resetn = 1'b0; lit(0, 0, 0); tick();
    resetn = 1'b1; lit(0, 0, 0); tick();
    lit(0, 0, 0); tick();

    idle(); tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
